// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV32I core.
// Walks each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath mux selects, write strobes, the
// immediate format and the ALU operation.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   op, funct3, funct7b5          instruction fields from the IR
//   Zero                          ALU zero flag (branch resolution)
//   MemReady                      memory finishes the current access this cycle
//   MemReq, AdrSrc, MemWrite      memory request, address select, write strobe
//   PCWrite, IRWrite, RegWrite    register enables
//   ResultSrc, ALUSrcA, ALUSrcB   datapath mux selects
//   ALUControl, ImmSrc            ALU operation, immediate extender format
//   Halted, State                 halt flag and current state for debug
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC once memory is ready
// DECODE   | read registers, OldPC+imm (branch target) into ALUOut
// MEMADR   | rs1+imm, the load/store address
// MEMREAD  | read data memory at ALUOut, wait for MemReady
// MEMWB    | load data -> rd
// MEMWRITE | write data memory at ALUOut, strobe held until MemReady
// EXECUTER | rs1 op rs2
// EXECUTEI | rs1 op imm
// ALUWB    | ALUOut -> rd
// BEQ      | compare rs1, rs2; take branch target from ALUOut if equal
// JAL      | OldPC+4 for the link, jump target from ALUOut -> PC
// HALT     | illegal opcode seen, everything idle until reset

module multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Halted,
  output logic [3:0] State
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_branch;
  logic       w_pc_update;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_BEQ:            w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) w_next = S_MEMWB;
      S_MEMWRITE: if (MemReady) w_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ:        w_next = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL:  w_next = S_ALUWB;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    MemReq      = 1'b0;
    AdrSrc      = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_alu_op    = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemReq      = 1'b1;
        w_ir_write  = MemReady;
        w_pc_update = MemReady;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq      = 1'b1;
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtract only for R-type with funct7b5; I-type add ignores Instr[30].
  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // Strobes are gated with rst_n so nothing is written while reset is held,
  // even though FETCH would otherwise pass MemReady through.
  assign PCWrite  = rst_n & (w_pc_update | (w_branch & Zero));
  assign IRWrite  = rst_n & w_ir_write;
  assign RegWrite = rst_n & w_reg_write;
  assign MemWrite = rst_n & w_mem_write;
  assign Halted   = (r_state == S_HALT);
  assign State    = r_state;

endmodule
